// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and multi-cycle
// mult/div freeze, plus a saturating counter of cycles with the PC held.
module hazard_control_unit #(
  parameter int MD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic        branch_taken,
  input  logic        muldiv_start,
  input  logic        perf_clr,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic [15:0] stall_cycles
);

  // state   | meaning
  // RUN     | normal issue; branch flush, mult/div entry and load-use stall decided here
  // MD_WAIT | remainder of a mult/div freeze; md_cnt counts down to the final cycle
  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MD_WAIT = 1'b1;

  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

  logic        r_state;
  logic [3:0]  r_md_cnt;
  logic [15:0] r_stall_cycles;

  logic        w_state_nxt;
  logic [3:0]  w_md_cnt_nxt;
  logic        w_load_use;

  assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    muldiv_busy  = 1'b0;
    muldiv_done  = 1'b0;
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;

    if (r_state == ST_MD_WAIT) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      muldiv_busy = 1'b1;
      if (r_md_cnt == 4'd0) begin
        muldiv_done = 1'b1;
        w_state_nxt = ST_RUN;
      end else begin
        w_md_cnt_nxt = r_md_cnt - 4'd1;
      end
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (muldiv_start) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      muldiv_busy  = 1'b1;
      w_md_cnt_nxt = MD_LOAD;
      w_state_nxt  = ST_MD_WAIT;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end

    // Outputs sit at their pass-through values for as long as reset is held.
    if (!rst_n) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      muldiv_busy = 1'b0;
      muldiv_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_md_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 16'd0;
    end else if (perf_clr) begin
      r_stall_cycles <= 16'd0;
    end else if (!pc_write && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: a cycle-level reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_hazard_control_unit;

  localparam int MDC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0;
  logic        muldiv_start = 1'b0, perf_clr = 1'b0;
  logic        pc_write, ifid_write, idex_write, ifid_flush, idex_bubble;
  logic        muldiv_busy, muldiv_done;
  logic [15:0] stall_cycles;

  hazard_control_unit #(.MD_CYCLES(MDC)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .muldiv_start(muldiv_start), .perf_clr(perf_clr), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_write(idex_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  ctl;   // {pc, ifid, idex, flush, bubble, busy, done}
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: freeze_left = frozen cycles still owed after the current one.
  int   m_freeze_left = 0;
  int   m_count = 0;

  task automatic step(input logic rst, input logic br, input logic md, input logic ld,
                      input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic clr);
    exp_t e;
    bit   hz, pcw, ifw, idw, fl, bb, bs, dn;
    @(posedge clk);
    #1;
    rst_n = rst; branch_taken = br; muldiv_start = md; ex_mem_read = ld;
    ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt; perf_clr = clr;
    pcw = 1; ifw = 1; idw = 1; fl = 0; bb = 0; bs = 0; dn = 0;
    if (!rst) begin
      m_freeze_left = 0;
      m_count = 0;
    end else if (m_freeze_left > 0) begin
      pcw = 0; ifw = 0; idw = 0; bs = 1;
      dn = (m_freeze_left == 1);
      m_freeze_left--;
    end else if (br) begin
      fl = 1; bb = 1;
    end else if (md) begin
      pcw = 0; ifw = 0; idw = 0; bs = 1;
      m_freeze_left = MDC - 1;
    end else begin
      hz = ld && ert != 0 && (ert == rs || (urt && ert == rt));
      if (hz) begin
        pcw = 0; ifw = 0; bb = 1;
      end
    end
    e.ctl = {pcw, ifw, idw, fl, bb, bs, dn};
    e.cnt = 16'(m_count);
    q.push_back(e);
    if (rst) begin
      if (clr) m_count = 0;
      else if (!pcw && m_count < 65535) m_count++;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (q.size() != 0) begin
      e = q.pop_front();
      act = {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, muldiv_busy, muldiv_done};
      tests++;
      if (act !== e.ctl) begin
        fails++;
        $display("FAIL ctl @%0t: got %b expected %b (pc,ifid,idex,flush,bubble,busy,done)",
                 $time, act, e.ctl);
      end
      tests++;
      if (stall_cycles !== e.cnt) begin
        fails++;
        $display("FAIL stall_cycles @%0t: got %h expected %h", $time, stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    // reset holds outputs at defaults even with a branch asserted
    step(0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0);
    step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    // load-use on rs, then the bubble arrives in EX
    step(1, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0, 0);
    idle();
    // load-use via rt only when rt is a source
    step(1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0);
    step(1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0);
    // zero register never hazards
    step(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
    // mult/div pulse then idle through the freeze
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (5) idle();
    // freeze ignores branch / start / load-use, then load-use re-evaluated once
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (3) step(1, 1, 1, 1, 5'd3, 5'd3, 5'd0, 0, 0);
    step(1, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0);
    idle();
    // priority: branch beats mult/div and load-use
    step(1, 1, 1, 1, 5'd9, 5'd9, 5'd9, 1, 0);
    idle();
    // reset in the 2nd MD_WAIT cycle
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    idle();
    // perf_clr wins over an increment
    step(1, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, 0);
    step(1, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, 1);
    idle();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           $urandom_range(0, 1),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1),
           ($urandom_range(0, 29) == 0));
    end
    // saturate the counter with continuous load-use stalls, then clear it
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    for (int i = 0; i < 65540; i++) step(1, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0);
    step(1, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 1);
    idle();
    idle();

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
